// File: rtl/vga_compositor.sv
// VGA scan-out with N-layer priority compositor and scene-change fade.
// Ports: clk/rst, bg_pixel, layer_pixel/valid/mask, scene_change in;
//        pix_en, h_cnt, v_cnt, hsync, vsync, vgaRed/Green/Blue,
//        frame_start, fade_busy out.
// LAYER_LAT must be at least 1.
module vga_compositor #(
    parameter int CLK_DIV          = 4,
    parameter int H_ACTIVE         = 640,
    parameter int H_FP             = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BP             = 48,
    parameter int V_ACTIVE         = 480,
    parameter int V_FP             = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BP             = 33,
    parameter int N_LAYERS         = 4,
    parameter int LAYER_LAT        = 1,
    parameter int FADE_STEP_FRAMES = 2,
    parameter logic [N_LAYERS-1:0] MASK_RESET = {N_LAYERS{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [11:0]            bg_pixel,
    input  logic [12*N_LAYERS-1:0] layer_pixel,
    input  logic [N_LAYERS-1:0]    layer_valid,
    input  logic [N_LAYERS-1:0]    layer_mask,
    input  logic                   scene_change,
    output logic                   pix_en,
    output logic [9:0]             h_cnt,
    output logic [9:0]             v_cnt,
    output logic                   hsync,
    output logic                   vsync,
    output logic [3:0]             vgaRed,
    output logic [3:0]             vgaGreen,
    output logic [3:0]             vgaBlue,
    output logic                   frame_start,
    output logic                   fade_busy
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DW       = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        SWAP,
        FADE_IN
    } state_t;

    // ---------------- pixel clock divider ----------------
    logic [DW-1:0] div_cnt;

    assign pix_en = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ---------------- raster counters ----------------
    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == 10'(H_TOTAL - 1));
    assign v_last = (v_cnt == 10'(V_TOTAL - 1));
    assign frame_start = pix_en & h_last & v_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // ---------------- sync / active generation ----------------
    logic hs_raw;
    logic vs_raw;
    logic act_raw;

    assign hs_raw  = !((h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END)));
    assign vs_raw  = !((v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END)));
    assign act_raw = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));

    // Delay sync/active by the layer latency so they meet the layer data.
    logic [LAYER_LAT-1:0] hs_dl;
    logic [LAYER_LAT-1:0] vs_dl;
    logic [LAYER_LAT-1:0] act_dl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_dl  <= '1;
            vs_dl  <= '1;
            act_dl <= '0;
        end else if (pix_en) begin
            hs_dl[0]  <= hs_raw;
            vs_dl[0]  <= vs_raw;
            act_dl[0] <= act_raw;
            for (int i = 1; i < LAYER_LAT; i++) begin
                hs_dl[i]  <= hs_dl[i-1];
                vs_dl[i]  <= vs_dl[i-1];
                act_dl[i] <= act_dl[i-1];
            end
        end
    end

    // ---------------- fade FSM ----------------
    state_t              state;
    state_t              state_n;
    logic [4:0]          level;
    logic [4:0]          level_n;
    logic [7:0]          frame_ctr;
    logic [7:0]          ctr_n;
    logic [N_LAYERS-1:0] mask_active;
    logic [N_LAYERS-1:0] act_n;
    logic [N_LAYERS-1:0] mask_pending;
    logic [N_LAYERS-1:0] pend_n;
    logic                step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            level        <= 5'd16;
            frame_ctr    <= '0;
            mask_active  <= MASK_RESET;
            mask_pending <= MASK_RESET;
        end else begin
            state        <= state_n;
            level        <= level_n;
            frame_ctr    <= ctr_n;
            mask_active  <= act_n;
            mask_pending <= pend_n;
        end
    end

    always_comb begin
        state_n = state;
        level_n = level;
        ctr_n   = frame_ctr;
        act_n   = mask_active;
        pend_n  = mask_pending;
        step    = 1'b0;

        if (frame_start) begin
            if (frame_ctr >= 8'(FADE_STEP_FRAMES - 1)) begin
                step = 1'b1;
            end else begin
                ctr_n = frame_ctr + 8'd1;
            end
        end

        if (scene_change) begin
            pend_n = layer_mask;
        end

        unique case (state)
            IDLE: begin
                ctr_n = '0;
                if (scene_change) begin
                    state_n = FADE_OUT;
                end
            end
            FADE_OUT: begin
                // Level 0 can be reached on entry via an abort at level 0.
                if (level == 5'd0) begin
                    state_n = SWAP;
                    ctr_n   = '0;
                end else if (step) begin
                    level_n = level - 5'd1;
                    ctr_n   = '0;
                    if (level == 5'd1) begin
                        state_n = SWAP;
                    end
                end
            end
            SWAP: begin
                if (frame_start) begin
                    act_n   = pend_n;
                    state_n = FADE_IN;
                    ctr_n   = '0;
                end
            end
            FADE_IN: begin
                if (scene_change) begin
                    state_n = FADE_OUT;
                    ctr_n   = '0;
                end else if (step) begin
                    level_n = level + 5'd1;
                    ctr_n   = '0;
                    if (level == 5'd15) begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign fade_busy = (state != IDLE);

    // ---------------- compose and scale ----------------
    logic [11:0] comp;

    // Walk from lowest to highest priority so the lowest index wins.
    always_comb begin
        comp = bg_pixel;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (layer_valid[k] && mask_active[k]) begin
                comp = layer_pixel[12*k +: 12];
            end
        end
    end

    function automatic logic [3:0] scale(input logic [3:0] c,
                                         input logic [4:0] lvl);
        logic [7:0] p;
        p = 8'(c) * 8'(lvl);
        return p[7:4];
    endfunction

    logic [11:0] rgb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_en) begin
            hsync <= hs_dl[LAYER_LAT-1];
            vsync <= vs_dl[LAYER_LAT-1];
            if (act_dl[LAYER_LAT-1]) begin
                rgb_q <= {scale(comp[11:8], level),
                          scale(comp[7:4], level),
                          scale(comp[3:0], level)};
            end else begin
                rgb_q <= '0;
            end
        end
    end

    assign vgaRed   = rgb_q[11:8];
    assign vgaGreen = rgb_q[7:4];
    assign vgaBlue  = rgb_q[3:0];

endmodule

// File: doc/vga_compositor.md
# vga_compositor

Parametrised VGA scan-out and layer compositor, the successor to the fixed 640x480, hard-wired-priority output stage. It generates pixel-enable, raster coordinates and sync from the system clock. It merges N_LAYERS priority-ordered sprite/text/laser layers over a background using a per-scene layer mask. It adds a frame-synchronous fade-out / mask-swap / fade-in sequence on scene changes.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per pixel (≥2).
- H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing in pixels.
- V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines.
- N_LAYERS, 4: composited layers; index 0 has the highest priority.
- LAYER_LAT, 1: pixel ticks from coordinate issue to layer data valid.
- FADE_STEP_FRAMES, 2: frames per brightness step (1..255).
- MASK_RESET, all ones: active layer mask after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- bg_pixel  in  12  background RGB444, aligned like the layers.
- layer_pixel  in  12*N_LAYERS  layer k occupies bits [12k+11:12k].
- layer_valid  in  N_LAYERS  per-layer opacity for the current pixel.
- layer_mask  in  N_LAYERS  requested mask for the next scene.
- scene_change  in  1  one-clk request to fade and swap the mask.
- pix_en  out  1  pixel tick, one clk wide.
- h_cnt, v_cnt  out  10  issued raster coordinate.
- hsync, vsync  out  1  active-low sync.
- vgaRed, vgaGreen, vgaBlue  out  4  RGB output.
- frame_start  out  1  pulse on the tick where (h_cnt,v_cnt) wraps to (0,0).
- fade_busy  out  1  high whenever the FSM is not IDLE.

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1. pix_en = (div_cnt==CLK_DIV-1).
- Raster: on pix_en, h_cnt increments and wraps at H_TOTAL-1 = 799 (default). On the h wrap, v_cnt increments and wraps at V_TOTAL-1 = 524.
- Sync: hsync is low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule on v. active = h<H_ACTIVE && v<V_ACTIVE.
- Alignment: hsync, vsync and active each pass through a LAYER_LAT-deep pix_en-enabled delay line, so they align with the layer and bg inputs.
- Compose: pick the lowest k with layer_valid[k] & mask_active[k]; if none, use bg_pixel.
- Output:
  - Output = compose scaled by the brightness level, 0 when not active.
  - Scaling per channel: (c*level)>>4 with an 8-bit product; level is 5 bits, 0..16.
  - The output register updates on pix_en.
- Fade FSM, stepping at frame_start when frame_ctr reaches FADE_STEP_FRAMES; frame_ctr clears on each step and on every state entry:
  - IDLE (level 16): on scene_change, latch layer_mask into mask_pending and go to FADE_OUT.
  - FADE_OUT: level -1 per step. When the level is 0, go to SWAP.
  - SWAP: on the next frame_start, set mask_active <= mask_pending and go to FADE_IN.
  - FADE_IN: level +1 per step. At level 16, go to IDLE.
  - scene_change during FADE_OUT or SWAP: update mask_pending only.
  - scene_change during FADE_IN: update mask_pending and go to FADE_OUT at the current level.
- Reset values:
  - div_cnt, h_cnt, v_cnt = 0; pix_en = 0 (div_cnt = 0).
  - hsync = vsync = 1; RGB = 0; frame_start = 0.
  - Delay lines cleared to inactive and sync high.
  - State IDLE, level 16, mask_active = mask_pending = MASK_RESET, fade_busy = 0.

## Timing
- pix_en first asserts CLK_DIV-1 clk edges after rst deasserts.
- Coordinate (h,v) appears on h_cnt/v_cnt on the tick it is issued. Its RGB and sync appear LAYER_LAT+1 pix ticks later.
- Layers sample h_cnt/v_cnt. Their data must be stable at the pix_en edge LAYER_LAT ticks after issue.
- frame_start and fade steps fall in vertical blanking, so brightness is constant within each visible frame.
- Full fade sequence with FADE_STEP_FRAMES=F:
  - FADE_OUT takes 16F frames.
  - SWAP takes 1 frame.
  - FADE_IN takes 16F frames.
  - fade_busy stays high for 32F+1 frame_starts.
- rst asserted mid-frame forces all reset values immediately, with no waiting for a clk edge. The raster restarts at (0,0).

## Test plan
- Reset, then release: pix_en has a period of 4 clk. The hsync low pulse lasts 96 ticks starting at h=656. The vsync low pulse lasts 2 lines starting at v=490. frame_start occurs every 420000 ticks.
- Priority: layer 0 = 0xF00, layer 2 = 0x0F0, valid = 4'b0101, all masked in → output 0xF00. With valid = 0, output equals bg_pixel.
- Latency: drive bg = h_cnt[3:0] replicated → the output at tick t equals the value for the coordinate issued at t-(LAYER_LAT+1). RGB = 0 outside the active region.
- Scene change with F=1, layer_mask = 4'b1110:
  - fade_busy is high for 33 frames, then mask_active = 1110.
  - Layer 0 is ignored afterwards.
  - When the level is 8, pixel 0xF84 is output as 0x742.
- scene_change during FADE_IN at level 10 → the next step gives level 9. mask_pending holds the new mask.
- rst pulsed mid-line during FADE_OUT → outputs return to reset values in the same cycle; state IDLE, level 16.
